// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns EX/MEM load/store controls into a registered
// req/ack data-memory transaction, stalling the pipeline until it completes.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        LoadMisalignM,
  output logic        StoreMisalignM,
  output logic        AccessFaultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  fsm_state
);

  // Bus handshake: dmem_req rises one cycle after IDLE accepts an access and stays
  // high with a stable payload until dmem_ack is sampled high (or the timeout fires).
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        access, legal, aligned;
  logic        start, ack_hit, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] cnt_q;
  logic        timed_out_q;

  assign fsm_state = state_q;
  assign access    = MemReadM | MemWriteM;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'b0, b};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  always_comb begin
    if (MemWriteM) legal = Funct3M inside {3'b000, 3'b001, 3'b010};
    else           legal = Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (Funct3M[1:0])
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    be_d    = 4'b1111;
    wdata_d = 32'b0;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          be_d    = 4'b0001 << ALUResultM[1:0];
          wdata_d = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{WriteDataM[15:0]}};
        end
        default: wdata_d = WriteDataM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    StallM         = 1'b0;
    LoadMisalignM  = 1'b0;
    StoreMisalignM = 1'b0;
    AccessFaultM   = 1'b0;
    start          = 1'b0;
    ack_hit        = 1'b0;
    timeout        = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if ((MemReadM & MemWriteM) | ~legal) begin
            AccessFaultM = 1'b1;
          end else if (!aligned) begin
            LoadMisalignM  = MemReadM;
            StoreMisalignM = MemWriteM;
          end else begin
            start   = 1'b1;
            StallM  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (dmem_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // EX/MEM still holds the finished instruction here, so never restart it.
        AccessFaultM = timed_out_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      StallM         = 1'b0;
      LoadMisalignM  = 1'b0;
      StoreMisalignM = 1'b0;
      AccessFaultM   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'b0;
      dmem_wdata  <= 32'b0;
      dmem_be     <= 4'b0;
      ReadDataM   <= 32'b0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      cnt_q       <= 16'b0;
      timed_out_q <= 1'b0;
    end else begin
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MemWriteM;
        dmem_addr  <= {ALUResultM[31:2], 2'b00};
        dmem_wdata <= wdata_d;
        dmem_be    <= be_d;
        f3_q       <= Funct3M;
        off_q      <= ALUResultM[1:0];
        cnt_q      <= 16'b0;
      end
      if (state_q == WAIT) cnt_q <= cnt_q + 16'd1;
      if (ack_hit) begin
        dmem_req  <= 1'b0;
        ReadDataM <= dmem_we ? 32'b0 : fmt_load(f3_q, off_q, dmem_rdata);
      end
      if (timeout) begin
        dmem_req    <= 1'b0;
        ReadDataM   <= 32'b0;
        timed_out_q <= 1'b1;
      end
      if (state_q == DONE) begin
        cnt_q       <= 16'b0;
        timed_out_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, faults, timeout and reset
// mid-transaction, with hand-computed expected values.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, LoadMisalignM, StoreMisalignM, AccessFaultM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [1:0]  fsm_state;

  int tests = 0;
  int fails = 0;
  int stalls, reqs;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .LoadMisalignM(LoadMisalignM), .StoreMisalignM(StoreMisalignM),
    .AccessFaultM(AccessFaultM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
  endtask

  // Presents one access starting next cycle; ack_k is the cycle (0 = accept cycle)
  // in which dmem_ack is driven. Returns positioned inside the completion cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_k, input logic [31:0] rdat);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    drive(rd, wr, f3, a, wd);
    stalls = 0;
    reqs   = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ack   = (c == ack_k);
      dmem_rdata = (c == ack_k) ? rdat : 32'h5A5A_5A5A;
      #1;
      if (StallM)   stalls++;
      if (dmem_req) reqs++;
      if (c == 1) begin
        cap_addr  = dmem_addr;
        cap_wdata = dmem_wdata;
        cap_be    = dmem_be;
        cap_we    = dmem_we;
      end
      if (c > 0 && !StallM) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    dmem_ack = 1'b0;
    chk("access_completes", {31'b0, done}, 32'd1);
  endtask

  initial begin
    // Reset with a legal access and then a fault-worthy access on the inputs.
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, dmem_req}, 32'd0);
    chk("rst_we",    {31'b0, dmem_we}, 32'd0);
    chk("rst_be",    {28'b0, dmem_be}, 32'd0);
    chk("rst_addr",  dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_stall", {31'b0, StallM}, 32'd0);
    drive(1'b1, 1'b1, 3'b011, 32'h101, 32'h0);
    #1;
    chk("rst_fault", {29'b0, AccessFaultM, LoadMisalignM, StoreMisalignM}, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // LW 0x100, ack in cycle 3: four stall cycles.
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    chk("lw_addr",   cap_addr, 32'h100);
    chk("lw_be",     {28'b0, cap_be}, 32'hF);
    chk("lw_we",     {31'b0, cap_we}, 32'd0);
    chk("lw_stalls", stalls, 32'd4);
    chk("lw_reqs",   reqs, 32'd3);
    chk("lw_data",   ReadDataM, 32'hDEAD_BEEF);
    chk("lw_req_done", {31'b0, dmem_req}, 32'd0);
    chk("lw_fault",  {31'b0, AccessFaultM}, 32'd0);

    // Back-to-back loads with extension, fastest ack.
    do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1, 32'h80AA_BBCC);
    chk("lb_data",   ReadDataM, 32'hFFFF_FF80);
    chk("lb_stalls", stalls, 32'd2);
    chk("lb_addr",   cap_addr, 32'h200);
    do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80AA_BBCC);
    chk("lbu_data",  ReadDataM, 32'h0000_0080);
    do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h80AA_BBCC);
    chk("lh_data",   ReadDataM, 32'hFFFF_80AA);
    do_access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 1, 32'h80AA_BBCC);
    chk("lhu_data",  ReadDataM, 32'h0000_BBCC);
    do_access(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 1, 32'h80AA_BBCC);
    chk("lb0_data",  ReadDataM, 32'hFFFF_FFCC);
    do_access(1'b1, 1'b0, 3'b100, 32'h201, 32'h0, 1, 32'h80AA_BBCC);
    chk("lbu1_data", ReadDataM, 32'h0000_00BB);

    // Timeout (limit 4): req for exactly 4 cycles, then fault with zero data.
    do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h0);
    chk("to_reqs",   reqs, 32'd4);
    chk("to_stalls", stalls, 32'd5);
    chk("to_fault",  {31'b0, AccessFaultM}, 32'd1);
    chk("to_data",   ReadDataM, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_ack_req",   {31'b0, dmem_req}, 32'd0);
    chk("late_ack_fault", {31'b0, AccessFaultM}, 32'd0);
    chk("nonmem_stall",   {31'b0, StallM}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_data",  ReadDataM, 32'd0);
    chk("late_ack_req2",  {31'b0, dmem_req}, 32'd0);

    // Stores: byte enables and lane replication.
    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h1111_2222);
    chk("pre_st_data", ReadDataM, 32'h1111_2222);
    do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 1, 32'hFFFF_FFFF);
    chk("sh_we",    {31'b0, cap_we}, 32'd1);
    chk("sh_be",    {28'b0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_addr",  cap_addr, 32'h100);
    chk("sh_rdata", ReadDataM, 32'd0);
    do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_0055, 2, 32'h0);
    chk("sb_be",    {28'b0, cap_be}, 32'h2);
    chk("sb_wdata", cap_wdata, 32'h5555_5555);
    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, 1, 32'h0);
    chk("sw_be",    {28'b0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("sw_addr",  cap_addr, 32'h104);

    // Misaligned and illegal accesses: one-cycle flags, never a request.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    chk("lmis_flag",  {31'b0, LoadMisalignM}, 32'd1);
    chk("lmis_stall", {31'b0, StallM}, 32'd0);
    chk("lmis_smis",  {31'b0, StoreMisalignM}, 32'd0);
    @(posedge clk); #1;
    chk("lmis_req",   {31'b0, dmem_req}, 32'd0);
    drive(1'b0, 1'b1, 3'b001, 32'h103, 32'h0);
    #1;
    chk("smis_flag",  {31'b0, StoreMisalignM}, 32'd1);
    chk("smis_fault", {31'b0, AccessFaultM}, 32'd0);
    @(posedge clk); #1;
    chk("smis_req",   {31'b0, dmem_req}, 32'd0);
    drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    #1;
    chk("f3_fault",   {31'b0, AccessFaultM}, 32'd1);
    chk("f3_stall",   {31'b0, StallM}, 32'd0);
    @(posedge clk); #1;
    chk("f3_req",     {31'b0, dmem_req}, 32'd0);
    drive(1'b0, 1'b1, 3'b100, 32'h100, 32'h0);
    #1;
    chk("st_f3_fault", {31'b0, AccessFaultM}, 32'd1);
    drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
    #1;
    chk("rw_fault",   {31'b0, AccessFaultM}, 32'd1);
    chk("rw_lmis",    {31'b0, LoadMisalignM}, 32'd0);
    @(posedge clk); #1;
    chk("rw_req",     {31'b0, dmem_req}, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("idle_fault", {31'b0, AccessFaultM}, 32'd0);

    // Reset while a store is waiting for its ack.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b010, 32'h104, 32'h7777_8888);
    @(posedge clk); #1;
    chk("wait_req", {31'b0, dmem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_rst_req",   {31'b0, dmem_req}, 32'd0);
    chk("rw_rst_we",    {31'b0, dmem_we}, 32'd0);
    chk("rw_rst_be",    {28'b0, dmem_be}, 32'd0);
    chk("rw_rst_addr",  dmem_addr, 32'd0);
    chk("rw_rst_stall", {31'b0, StallM}, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 2, 32'h1234_5678);
    chk("post_rst_stalls", stalls, 32'd3);
    chk("post_rst_addr",   cap_addr, 32'h108);
    chk("post_rst_data",   ReadDataM, 32'h1234_5678);
    chk("post_rst_fault",  {31'b0, AccessFaultM}, 32'd0);

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
